// File: rtl/tinker_pkg.sv
// Shared Tinker ISA definitions: opcode encodings, the instruction field
// layout, the default reset PC and a halt-decode helper used by fetch.
package tinker_pkg;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h2000;

   typedef enum logic [4:0] {
      OPC_AND    = 5'h00,
      OPC_OR     = 5'h01,
      OPC_XOR    = 5'h02,
      OPC_NOT    = 5'h03,
      OPC_SHFTR  = 5'h04,
      OPC_SHFTRI = 5'h05,
      OPC_SHFTL  = 5'h06,
      OPC_SHFTLI = 5'h07,
      OPC_BR     = 5'h08,
      OPC_BRR    = 5'h09,
      OPC_BRRL   = 5'h0A,
      OPC_BRNZ   = 5'h0B,
      OPC_CALL   = 5'h0C,
      OPC_RETURN = 5'h0D,
      OPC_BRGT   = 5'h0E,
      OPC_PRIV   = 5'h0F,
      OPC_ADD    = 5'h18,
      OPC_ADDI   = 5'h19,
      OPC_SUB    = 5'h1A,
      OPC_SUBI   = 5'h1B,
      OPC_MUL    = 5'h1C,
      OPC_DIV    = 5'h1D
   } opcode_e;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [11:0] lit;
   } instr_t;

   // A priv instruction with a zero literal is the halt instruction.
   function automatic logic is_halt(input logic [31:0] word);
      instr_t f;
      f = instr_t'(word);
      return (f.opcode == OPC_PRIV) && (f.lit == '0);
   endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Small synchronous in-order FIFO with flush. Used both as the fetched
// instruction buffer and as the side queue of outstanding request PCs.
module tinker_fetch_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign head    = mem[rd_ptr];

   // Entry storage; contents need no reset because count qualifies them.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the queue at once.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction fetch stage: owns the PC, issues credit-limited reads
// to instruction memory, buffers responses with their PCs and hands them to
// tinker_core on a valid/ready handshake. Redirects flush the buffer and
// discard responses still in flight.
// Optional halt detection is enabled by defining TINKER_FETCH_HALT_DETECT_EN.
module tinker_fetch
   import tinker_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [63:0] instr_pc,
   output logic        fetch_halted
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   logic [63:0]   pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop;
   logic [CW-1:0] count;
   logic [CW-1:0] pcq_count;
   logic          halted;
   logic [95:0]   head;
   logic [63:0]   pcq_head;
   logic [CW:0]   credit;
   logic          req_fire;
   logic          resp_ok;
   logic          push;
   logic          pop;
   logic          halt_hit;

   // Outstanding requests plus buffered words may never exceed the buffer.
   assign credit         = {1'b0, inflight} + {1'b0, count};
   assign imem_req_valid = !reset && !redirect_valid && !halted &&
                           (credit < (CW+1)'(BUF_DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is ignored.
   assign resp_ok = imem_resp_valid && (inflight != '0);
   assign push    = resp_ok && !redirect_valid && (drop == '0);

   assign instr_valid = (count != '0) && !redirect_valid;
   assign pop         = instr_valid && instr_ready;
   assign instruction = (count != '0) ? head[31:0]  : '0;
   assign instr_pc    = (count != '0) ? head[95:32] : '0;

`ifdef TINKER_FETCH_HALT_DETECT_EN
   assign halt_hit     = push && is_halt(imem_resp_data);
   assign fetch_halted = halted;
`else
   assign halt_hit     = 1'b0;
   assign fetch_halted = 1'b0;
`endif

   tinker_fetch_fifo #(
      .WIDTH (64),
      .DEPTH (BUF_DEPTH)
   ) u_pc_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data (pc),
      .pop       (resp_ok),
      .flush     (1'b0),
      .head      (pcq_head),
      .count     (pcq_count)
   );

   tinker_fetch_fifo #(
      .WIDTH (96),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({pcq_head, imem_resp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (count)
   );

   // PC, outstanding/drop accounting and halt flag; redirect overrides all.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         halted   <= 1'b0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(resp_ok);
         if (redirect_valid) begin
            pc     <= {redirect_pc[63:2], 2'b00};
            // inflight already includes responses pending a drop, so every
            // response still outstanding after this cycle is stale.
            drop   <= inflight - CW'(resp_ok);
            halted <= 1'b0;
         end else begin
            if (req_fire) pc <= pc + 64'd4;
            if (halt_hit) begin
               halted <= 1'b1;
               drop   <= inflight + CW'(req_fire) - CW'(resp_ok);
            end else if (resp_ok && (drop != '0)) begin
               drop <= drop - CW'(1);
            end
         end
      end
   end

   a_resp_outstanding: assert property (@(posedge clk) disable iff (reset)
      imem_resp_valid |-> (inflight != '0));

   a_pc_queue_tracks: assert property (@(posedge clk) disable iff (reset)
      pcq_count == inflight);

endmodule

// File: tb/tb_tinker_fetch.sv
// Directed bench for tinker_fetch with a configurable-latency memory model.
// Halt checks follow TINKER_FETCH_HALT_DETECT_EN.
module tb_tinker_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instruction;
   logic [63:0] instr_pc;
   logic        fetch_halted;

   int total = 0;
   int bad = 0;

   int unsigned lat = 1;
   logic        halt_en = 1'b0;
   logic [63:0] halt_addr = 64'h2008;
   logic        pv [8];
   logic [63:0] pa [8];

   tinker_fetch #(
      .RESET_PC  (64'h2000),
      .BUF_DEPTH (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instruction     (instruction),
      .instr_pc        (instr_pc),
      .fetch_halted    (fetch_halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input logic [63:0] a);
      if (halt_en && a == halt_addr) return 32'h78000000;
      return 32'hC8000000 | {20'b0, a[11:0]};
   endfunction

   // Fixed-latency in-order memory, cleared by the shared reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
      end else begin
         for (int i = 0; i < 7; i++) begin
            pv[i] <= pv[i+1];
            pa[i] <= pa[i+1];
         end
         pv[7] <= 1'b0;
         if (imem_req_valid && imem_req_ready) begin
            pv[lat-1] <= 1'b1;
            pa[lat-1] <= imem_req_addr;
         end
      end
   end

   assign imem_resp_valid = pv[0];
   assign imem_resp_data  = pv[0] ? exp_word(pa[0]) : 32'h0;

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      lat = 1; halt_en = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
      apply_reset();
      #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
      total++; if (imem_req_addr !== 64'h2000) begin bad++; $display("FAIL reset_req_addr got=%h want=2000", imem_req_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
      total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instruction got=%h want=0", instruction); end
      total++; if (instr_pc !== 64'h0) begin bad++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
      total++; if (fetch_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", fetch_halted); end
   endtask

   task automatic test_stream();
      logic [63:0] e;
      lat = 1; halt_en = 1'b0; instr_ready = 1'b1;
      apply_reset();
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         e = 64'h2000 + 64'(c * 4);
         total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin bad++; $display("FAIL stream_req c=%0d got=%b/%h want=1/%h", c, imem_req_valid, imem_req_addr, e); end
         if (c >= 2) begin
            e = 64'h2000 + 64'((c - 2) * 4);
            total++; if (instr_valid !== 1'b1 || instr_pc !== e || instruction !== exp_word(e)) begin bad++; $display("FAIL stream_out c=%0d got=%b/%h/%h want=1/%h/%h", c, instr_valid, instr_pc, instruction, e, exp_word(e)); end
         end else begin
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_early c=%0d got=%b want=0", c, instr_valid); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] e;
      lat = 1; halt_en = 1'b0; instr_ready = 1'b0;
      apply_reset();
      reset = 1'b0;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 8) instr_ready = 1'b1;
         #1;
         if (c >= 2 && c <= 7) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h2000 || instruction !== exp_word(64'h2000)) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%h want=1/2000/%h", c, instr_valid, instr_pc, instruction, exp_word(64'h2000)); end
         end
         if (c >= 4 && c <= 8) begin
            total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h2010) begin bad++; $display("FAIL bp_stall c=%0d got=%b/%h want=0/2010", c, imem_req_valid, imem_req_addr); end
         end
         if (c == 9) begin
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2010) begin bad++; $display("FAIL bp_resume got=%b/%h want=1/2010", imem_req_valid, imem_req_addr); end
         end
         if (c >= 8) begin
            e = 64'h2000 + 64'((c - 8) * 4);
            total++; if (instr_valid !== 1'b1 || instr_pc !== e || instruction !== exp_word(e)) begin bad++; $display("FAIL bp_drain c=%0d got=%b/%h/%h want=1/%h/%h", c, instr_valid, instr_pc, instruction, e, exp_word(e)); end
         end
      end
   endtask

   task automatic test_redirect_stale();
      lat = 3; halt_en = 1'b0; instr_ready = 1'b1;
      apply_reset();
      reset = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         redirect_valid = (c == 2);
         redirect_pc = 64'h3001;
         #1;
         if (c == 2) begin
            total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL stale_redir_cycle got=%b/%b want=0/0", imem_req_valid, instr_valid); end
         end
         if (c == 3) begin
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin bad++; $display("FAIL stale_new_req got=%b/%h want=1/3000", imem_req_valid, imem_req_addr); end
         end
         if (c >= 3 && c <= 6) begin
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stale_not_dropped c=%0d got=%b/%h want=0", c, instr_valid, instr_pc); end
         end
         if (c == 7) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h3000 || instruction !== 32'hC8000000) begin bad++; $display("FAIL stale_first got=%b/%h/%h want=1/3000/c8000000", instr_valid, instr_pc, instruction); end
         end
         if (c == 8) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h3004) begin bad++; $display("FAIL stale_second got=%b/%h want=1/3004", instr_valid, instr_pc); end
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_redirect_collision();
      lat = 1; halt_en = 1'b0; instr_ready = 1'b1;
      apply_reset();
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         redirect_valid = (c == 3);
         redirect_pc = 64'h4000;
         #1;
         if (c == 3) begin
            total++; if (imem_resp_valid !== 1'b1) begin bad++; $display("FAIL coll_setup_resp got=%b want=1", imem_resp_valid); end
            total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL coll_redir_cycle got=%b/%b want=0/0", instr_valid, imem_req_valid); end
         end
         if (c == 4) begin
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL coll_flushed got=%b/%h want=0", instr_valid, instr_pc); end
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4000) begin bad++; $display("FAIL coll_new_req got=%b/%h want=1/4000", imem_req_valid, imem_req_addr); end
         end
         if (c == 5) begin
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL coll_early got=%b want=0", instr_valid); end
         end
         if (c >= 6) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h4000 + 64'((c - 6) * 4)) begin bad++; $display("FAIL coll_out c=%0d got=%b/%h want=1/%h", c, instr_valid, instr_pc, 64'h4000 + 64'((c - 6) * 4)); end
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_halt();
      lat = 1; halt_en = 1'b1; halt_addr = 64'h2008; instr_ready = 1'b1;
      apply_reset();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         redirect_valid = (c == 6);
         redirect_pc = 64'h2000;
         #1;
         if (c == 3) begin
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200C || fetch_halted !== 1'b0) begin bad++; $display("FAIL halt_pre got=%b/%h/%b want=1/200c/0", imem_req_valid, imem_req_addr, fetch_halted); end
         end
         if (c == 4) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h2008 || instruction !== 32'h78000000) begin bad++; $display("FAIL halt_deliver got=%b/%h/%h want=1/2008/78000000", instr_valid, instr_pc, instruction); end
         end
`ifdef TINKER_FETCH_HALT_DETECT_EN
         if (c >= 4 && c <= 5) begin
            total++; if (fetch_halted !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_stop c=%0d got=%b/%b want=1/0", c, fetch_halted, imem_req_valid); end
         end
         if (c == 5) begin
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_younger_dropped got=%b/%h want=0", instr_valid, instr_pc); end
         end
         if (c == 7) begin
            total++; if (fetch_halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin bad++; $display("FAIL halt_resume got=%b/%b/%h want=0/1/2000", fetch_halted, imem_req_valid, imem_req_addr); end
         end
         if (c == 9) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h2000) begin bad++; $display("FAIL halt_resume_out got=%b/%h want=1/2000", instr_valid, instr_pc); end
         end
`else
         if (c == 4) begin
            total++; if (fetch_halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2010) begin bad++; $display("FAIL nohalt_continue got=%b/%b/%h want=0/1/2010", fetch_halted, imem_req_valid, imem_req_addr); end
         end
         if (c == 5) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h200C || fetch_halted !== 1'b0) begin bad++; $display("FAIL nohalt_next got=%b/%h/%b want=1/200c/0", instr_valid, instr_pc, fetch_halted); end
         end
`endif
      end
      redirect_valid = 1'b0;
      halt_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_stale();
      test_redirect_collision();
      test_halt();
      apply_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
